// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle instruction sequencer FSM with memory wait timeout,
// sticky halt/fault status and free-running cycle/retire counters.
module core_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_ebreak,
    input  logic        illegal,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_wr_en,
    output logic        pc_en,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        ld_q, ld_d, st_q, st_d, eb_q, eb_d, il_q, il_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_q, instret_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            ld_q        <= 1'b0;
            st_q        <= 1'b0;
            eb_q        <= 1'b0;
            il_q        <= 1'b0;
            cycle_cnt_q <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            ld_q        <= ld_d;
            st_q        <= st_d;
            eb_q        <= eb_d;
            il_q        <= il_d;
            cycle_cnt_q <= cycle_cnt_d;
            instret_q   <= instret_d;
        end
    end

    // wait_d defaults to zero so any entry into FETCH or MEM starts a fresh count
    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        ld_d        = ld_q;
        st_d        = st_q;
        eb_d        = eb_q;
        il_d        = il_q;
        instret_d   = instret_q;
        cycle_cnt_d = cycle_cnt_q + 32'((state_q >= FETCH) && (state_q <= WB));
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_wr_en    = 1'b0;
        pc_en       = 1'b0;
        case (state_q)
            IDLE: state_d = enable ? FETCH : IDLE;
            FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
                if (imem_ack) state_d = DECODE;
                else if (wait_q == WAIT_LAST) state_d = FAULT;
                else wait_d = wait_q + 8'd1;
            end
            DECODE: begin
                ld_d    = is_load;
                st_d    = is_store;
                eb_d    = is_ebreak;
                il_d    = illegal;
                state_d = illegal ? FAULT : is_ebreak ? HALT : EXEC;
            end
            EXEC: state_d = (ld_q || st_q) ? MEM : WB;
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = st_q;
                if (dmem_ack) state_d = WB;
                else if (wait_q == WAIT_LAST) state_d = FAULT;
                else wait_d = wait_q + 8'd1;
            end
            WB: begin
                pc_en     = 1'b1;
                rf_wr_en  = !st_q;
                instret_d = instret_q + 32'd1;
                state_d   = enable ? FETCH : IDLE;
            end
            HALT:  state_d = HALT;
            FAULT: state_d = FAULT;
        endcase
    end

    assign halted    = (state_q == HALT);
    assign fault     = (state_q == FAULT);
    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instret   = instret_q;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: table-driven instruction scenarios plus hand-written
// sequences for async reset, sticky halt, enable drop and counter wrap.
module tb_core_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic        is_ebreak = 1'b0;
    logic        illegal = 1'b0;
    logic        imem_req, ir_load, dmem_req, dmem_we, rf_wr_en, pc_en, halted, fault;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instret;

    int errors = 0;
    int checks = 0;

    core_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .enable(enable), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak), .illegal(illegal),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_wr_en(rf_wr_en), .pc_en(pc_en), .halted(halted), .fault(fault),
        .state(state), .cycle_cnt(cycle_cnt), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       ld, st, eb, il;
        int         iw, dw;
        logic [2:0] fin;
        int         cyc, ins, ireq, irl, dreq, dwe, rfw, pce;
    } vec_t;

    vec_t vecs[9];
    int n_ireq, n_irl, n_dreq, n_dwe, n_rfw, n_pce, n_act;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        {is_load, is_store, is_ebreak, illegal} = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int fc, mc;
        fc = 0;
        mc = 0;
        {n_ireq, n_irl, n_dreq, n_dwe, n_rfw, n_pce, n_act} = '0;
        do_reset();
        {is_load, is_store, is_ebreak, illegal} = {v.ld, v.st, v.eb, v.il};
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        while (state inside {[3'd1:3'd5]} && n_act < 100) begin
            imem_ack = (state == 3'd1) && (fc == v.iw);
            dmem_ack = (state == 3'd4) && (mc == v.dw);
            if (state == 3'd1) fc++;
            if (state == 3'd4) mc++;
            #1;
            n_ireq += int'(imem_req);
            n_irl  += int'(ir_load);
            n_dreq += int'(dmem_req);
            n_dwe  += int'(dmem_we);
            n_rfw  += int'(rf_wr_en);
            n_pce  += int'(pc_en);
            n_act++;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        check({v.name, " bound"}, 32'(n_act < 100), 32'd1);
        check({v.name, " state"}, 32'(state), 32'(v.fin));
        check({v.name, " active"}, n_act, v.cyc);
        check({v.name, " cycle_cnt"}, cycle_cnt, v.cyc);
        check({v.name, " instret"}, instret, v.ins);
        check({v.name, " halted"}, 32'(halted), 32'(v.fin == 3'd6));
        check({v.name, " fault"}, 32'(fault), 32'(v.fin == 3'd7));
        check({v.name, " imem_req"}, n_ireq, v.ireq);
        check({v.name, " ir_load"}, n_irl, v.irl);
        check({v.name, " dmem_req"}, n_dreq, v.dreq);
        check({v.name, " dmem_we"}, n_dwe, v.dwe);
        check({v.name, " rf_wr_en"}, n_rfw, v.rfw);
        check({v.name, " pc_en"}, n_pce, v.pce);
    endtask

    initial begin
        //          name          ld st eb il  iw   dw   fin cyc ins ireq irl dreq dwe rfw pce
        vecs[0] = '{"alu",        0, 0, 0, 0,  0,   0,   0,  4,  1,  1,   1,  0,   0,  1,  1};
        vecs[1] = '{"store_w3",   0, 1, 0, 0,  0,   3,   0,  8,  1,  1,   1,  4,   4,  0,  1};
        vecs[2] = '{"load_iw2",   1, 0, 0, 0,  2,   1,   0,  8,  1,  3,   1,  2,   0,  1,  1};
        vecs[3] = '{"ebreak",     0, 0, 1, 0,  0,   0,   6,  2,  0,  1,   1,  0,   0,  0,  0};
        vecs[4] = '{"ill_ebreak", 0, 0, 1, 1,  0,   0,   7,  2,  0,  1,   1,  0,   0,  0,  0};
        vecs[5] = '{"imem_tmo",   0, 0, 0, 0,  255, 0,   7,  15, 0,  15,  0,  0,   0,  0,  0};
        vecs[6] = '{"imem_ack15", 0, 0, 0, 0,  14,  0,   0,  18, 1,  15,  1,  0,   0,  1,  1};
        vecs[7] = '{"dmem_tmo",   1, 0, 0, 0,  0,   255, 7,  18, 0,  1,   1,  15,  0,  0,  0};
        vecs[8] = '{"dmem_ack15", 0, 1, 0, 0,  0,   14,  0,  19, 1,  1,   1,  15,  15, 0,  1};

        #1;
        check("reset outputs", 32'({imem_req, ir_load, dmem_req, dmem_we, rf_wr_en, pc_en, halted, fault, state}), 32'd0);
        check("reset counters", cycle_cnt | instret, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back ALU instructions with enable held: 1,2,3,5,1
        begin
            logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
            do_reset();
            enable = 1'b1;
            imem_ack = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                #1;
                check($sformatf("seq state %0d", k), 32'(state), 32'(exp_st[k]));
                if (k == 3) check("seq wb strobes", 32'({rf_wr_en, pc_en}), 32'd3);
            end
            check("seq instret", instret, 32'd1);
            check("seq cycle_cnt", cycle_cnt, 32'd4);
        end

        // Enable dropped in EXEC: WB completes, then IDLE with cycle_cnt frozen
        do_reset();
        enable = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("drop in exec", 32'(state), 32'd3);
        enable = 1'b0;
        @(negedge clk);
        #1;
        check("drop wb", 32'(state), 32'd5);
        repeat (5) @(negedge clk);
        #1;
        check("drop idle", 32'(state), 32'd0);
        check("drop cycle frozen", cycle_cnt, 32'd4);
        check("drop instret", instret, 32'd1);
        dmem_ack = 1'b1;
        #1;
        check("stray acks ignored", 32'({ir_load, dmem_req, state}), 32'd0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        // HALT is terminal and silent
        do_reset();
        is_ebreak = 1'b1;
        enable = 1'b1;
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        dmem_ack = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("halt sticky", 32'(state), 32'd6);
        check("halt strobes", 32'({imem_req, ir_load, dmem_req, dmem_we, rf_wr_en, pc_en, halted, fault}), 32'h02);
        check("halt cycle frozen", cycle_cnt, 32'd2);

        // Async reset while in MEM with dmem_req high
        do_reset();
        is_store = 1'b1;
        enable = 1'b1;
        imem_ack = 1'b1;
        for (int k = 0; k < 10 && state != 3'd4; k++) @(negedge clk);
        #1;
        check("pre-reset mem", 32'({state, dmem_req, dmem_we}), 32'({3'd4, 2'b11}));
        reset = 1'b1;
        #1;
        check("async reset outputs", 32'({imem_req, ir_load, dmem_req, dmem_we, rf_wr_en, pc_en, halted, fault, state}), 32'd0);
        check("async reset counters", cycle_cnt | instret, 32'd0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset idle", 32'(state), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("post-reset fetch", 32'(state), 32'd1);

        // instret wraps from all-ones to zero
        do_reset();
        imem_ack = 1'b1;
        force dut.instret_q = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.instret_q;
        #1;
        check("instret preload", instret, 32'hFFFF_FFFF);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 20 && state != 3'd0; k++) @(negedge clk);
        #1;
        check("instret wrap", instret, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: wait cycles allowed in FETCH or MEM without ack before FAULT; legal range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 enable  in  1  run request; sampled in IDLE and WB.
REQ-005 imem_ack  in  1  instruction memory has valid instruction this cycle.
REQ-006 dmem_ack  in  1  data memory has completed the access this cycle.
REQ-007 is_load, is_store, is_ebreak, illegal  in  1 each  decoder flags for the current instruction.
REQ-008 imem_req  out  1  instruction fetch request.
REQ-009 ir_load  out  1  one-cycle strobe to capture the instruction register.
REQ-010 dmem_req  out  1  data memory request; dmem_we  out  1  store qualifier.
REQ-011 rf_wr_en  out  1  register-file write strobe; pc_en  out  1  program-counter advance strobe.
REQ-012 halted  out  1; fault  out  1  sticky status flags.
REQ-013 state  out  3  current FSM encoding; cycle_cnt  out  32  active cycles; instret  out  32  retired instructions.

Function
REQ-014 States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
REQ-015 IDLE: enable=1 -> FETCH next cycle; otherwise remain in IDLE.
REQ-016 FETCH: imem_req=1; imem_ack=1 -> ir_load=1 in the same cycle, then DECODE.
REQ-017 DECODE: latch is_load, is_store, is_ebreak, illegal; illegal -> FAULT (priority 1); is_ebreak -> HALT (priority 2); else EXEC.
REQ-018 EXEC: exactly one cycle; latched load or store -> MEM; else WB.
REQ-019 MEM: dmem_req=1; dmem_we=latched is_store; dmem_ack=1 -> WB.
REQ-020 WB: one cycle; pc_en=1; rf_wr_en=1 unless latched is_store; instret+1; then FETCH if enable=1, else IDLE.
REQ-021 Deasserting enable mid-instruction does not abort; the instruction completes through WB, then enters IDLE.
REQ-022 HALT: halted=1; FAULT: fault=1; both terminal until reset; no strobes asserted.
REQ-023 Wait counter, 8 bits: cleared on entry to FETCH or MEM; increments each cycle without ack; reaching MEM_TIMEOUT without ack -> FAULT.
REQ-024 Ack in the same cycle the counter reaches MEM_TIMEOUT: the ack wins and normal transition occurs.
REQ-025 cycle_cnt increments every cycle in FETCH..WB; it holds in IDLE, HALT and FAULT.
REQ-026 cycle_cnt and instret wrap modulo 2^32 (0xFFFFFFFF -> 0) with no flag.
REQ-027 All strobe outputs are Moore-decoded from state, except ir_load, which also requires imem_ack; no strobe lasts more than one cycle per instruction.
REQ-028 Acks arriving outside their own state (imem_ack outside FETCH, dmem_ack outside MEM) are ignored.

Reset
REQ-029 While reset=1 the block shall be in this condition: state=IDLE; all strobes=0; halted=0; fault=0; cycle_cnt=0; instret=0; wait counter=0; latched flags=0.
REQ-030 Reset asserted mid-operation (any state, including MEM with dmem_req high) drops every output to its reset value without waiting for clk.
REQ-031 After reset deasserts, the first transition shall be IDLE -> FETCH, at the first rising edge with enable=1.

Verification
REQ-032 ALU instruction, acks immediate, enable=1 -> states 1,2,3,5,1; rf_wr_en=1 and pc_en=1 in WB; instret=1 after 4 cycles.
REQ-033 Store with dmem_ack after 3 waits -> dmem_req high 4 cycles with dmem_we=1; rf_wr_en=0 in WB; pc_en=1.
REQ-034 MEM_TIMEOUT=15, imem_ack never asserted -> FAULT after 15 FETCH wait cycles; fault=1 held; ack on the 15th cycle instead -> DECODE.
REQ-035 illegal=1 and is_ebreak=1 together in DECODE -> FAULT, halted=0; is_ebreak alone -> HALT, halted=1; instret unchanged in both cases.
REQ-036 enable dropped during EXEC -> WB completes, then IDLE; cycle_cnt frozen in IDLE; reset pulse in MEM -> outputs zero asynchronously, state=0.
REQ-037 Preload instret=0xFFFFFFFF (force) and retire one instruction -> instret=0.
